// File: rtl/ram_wb_pkg.sv
// Shared state encoding, request payload and word/nibble address mapping
// for the word-to-nibble backdoor arbiter.
package ram_wb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam int unsigned NIBBLES_PER_WORD = 8;
  localparam int unsigned NIB_W            = 3;
  localparam int unsigned WORD_W           = 4;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned SEL_W            = 4;
  localparam int unsigned MEM_WORDS_DEF    = 8;
  localparam int unsigned STATUS_WORDS_DEF = 2;
  localparam int unsigned STATUS_BASE_DEF  = 64;

  // Upstream request latched at grant time.
  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] word;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] wdata;
  } wb_req_t;

  // Memory words map linearly; status words start at status_base.
  function automatic logic [DATA_W-1:0] nib_addr(input logic [WORD_W-1:0] word,
                                                 input logic [NIB_W-1:0]  nib,
                                                 input int unsigned       mem_words,
                                                 input int unsigned       status_base);
    if (32'(word) < mem_words) return DATA_W'({word, nib});
    return DATA_W'(status_base) + DATA_W'({WORD_W'(32'(word) - mem_words), nib});
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; a tie goes to the port opposite the last one served.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       served_i,
  output logic       gnt_vld_c_o,
  output logic       gnt_idx_c_o
);

  logic last_q, last_d;

  always_ff @(posedge clock) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if (update_i) last_d = served_i;
  end

  always_comb begin
    gnt_vld_c_o = |req_i;
    gnt_idx_c_o = 1'b0;
    case (req_i)
      2'b10:   gnt_idx_c_o = 1'b1;
      2'b11:   gnt_idx_c_o = ~last_q;
      default: gnt_idx_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ram_wb_word_arbiter.sv
// Shares the nibble backdoor between two 32-bit wishbone ports, splitting each
// word into eight LSB-first nibble accesses. RAM_WB_SEL_EN adds byte-lane selects.
module ram_wb_word_arbiter
  import ram_wb_pkg::*;
#(
  parameter int unsigned MEM_WORDS    = MEM_WORDS_DEF,
  parameter int unsigned STATUS_WORDS = STATUS_WORDS_DEF,
  parameter int unsigned STATUS_BASE  = STATUS_BASE_DEF
) (
  input  logic              clock,
  input  logic              reset,
`ifdef RAM_WB_SEL_EN
  input  logic [SEL_W-1:0]  s0_sel_i,
  input  logic [SEL_W-1:0]  s1_sel_i,
`endif
  input  logic              s0_cyc_i,
  input  logic              s0_stb_i,
  input  logic              s0_we_i,
  input  logic [DATA_W-1:0] s0_adr_i,
  input  logic [DATA_W-1:0] s0_dat_i,
  output logic [DATA_W-1:0] s0_dat_o,
  output logic              s0_ack_o,
  input  logic              s1_cyc_i,
  input  logic              s1_stb_i,
  input  logic              s1_we_i,
  input  logic [DATA_W-1:0] s1_adr_i,
  input  logic [DATA_W-1:0] s1_dat_i,
  output logic [DATA_W-1:0] s1_dat_o,
  output logic              s1_ack_o,
  output logic              m_cyc_o,
  output logic              m_stb_o,
  output logic              m_we_o,
  output logic [DATA_W-1:0] m_adr_o,
  output logic [DATA_W-1:0] m_dat_o,
  input  logic [DATA_W-1:0] m_dat_i,
  input  logic              m_ack_i,
  output logic              grant_o,
  output logic              busy_o
);

  localparam logic [NIB_W-1:0] LAST_NIB = NIB_W'(NIBBLES_PER_WORD - 1);

  state_e            state_q, state_d;
  wb_req_t           req_q, req_d, in_req_c;
  logic              port_q, port_d;
  logic [NIB_W-1:0]  nib_q, nib_d, nib_nxt_c;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              m_act_q, m_act_d, m_we_q, m_we_d;
  logic [DATA_W-1:0] m_adr_q, m_adr_d;
  logic [3:0]        m_dat_q, m_dat_d;
  logic              s0_ack_q, s0_ack_d, s1_ack_q, s1_ack_d;
  logic [DATA_W-1:0] s0_dat_q, s0_dat_d, s1_dat_q, s1_dat_d;
  logic              busy_q, busy_d;
  logic [SEL_W-1:0]  s0_sel_c, s1_sel_c;
  logic              gnt_vld_c, gnt_idx_c, arb_upd_c, in_ok_c, cur_en_c, nxt_en_c;
  logic              unused_c;

`ifdef RAM_WB_SEL_EN
  assign s0_sel_c = s0_sel_i;
  assign s1_sel_c = s1_sel_i;
`else
  assign s0_sel_c = '1;
  assign s1_sel_c = '1;
`endif

  // A port is masked during its own ack cycle so a held stb is not re-granted.
  rr_arbiter2 u_arb (
    .clock       (clock),
    .reset       (reset),
    .req_i       ({s1_cyc_i & s1_stb_i & ~s1_ack_q, s0_cyc_i & s0_stb_i & ~s0_ack_q}),
    .update_i    (arb_upd_c),
    .served_i    (port_q),
    .gnt_vld_c_o (gnt_vld_c),
    .gnt_idx_c_o (gnt_idx_c)
  );

  always_comb begin
    if (gnt_idx_c) in_req_c = '{we: s1_we_i, word: s1_adr_i[5:2], sel: s1_sel_c, wdata: s1_dat_i};
    else           in_req_c = '{we: s0_we_i, word: s0_adr_i[5:2], sel: s0_sel_c, wdata: s0_dat_i};
  end

  assign in_ok_c   = (32'(in_req_c.word) < MEM_WORDS + STATUS_WORDS) && (in_req_c.sel != '0);
  assign nib_nxt_c = nib_q + NIB_W'(1);
  assign cur_en_c  = req_q.sel[nib_q[2:1]];
  assign nxt_en_c  = req_q.sel[nib_nxt_c[2:1]];
  assign unused_c  = ^{s0_adr_i[31:6], s0_adr_i[1:0], s1_adr_i[31:6], s1_adr_i[1:0], m_dat_i[31:4]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      req_q    <= '0;
      port_q   <= 1'b0;
      nib_q    <= '0;
      rdata_q  <= '0;
      m_act_q  <= 1'b0;
      m_we_q   <= 1'b0;
      m_adr_q  <= '0;
      m_dat_q  <= '0;
      s0_ack_q <= 1'b0;
      s1_ack_q <= 1'b0;
      s0_dat_q <= '0;
      s1_dat_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      port_q   <= port_d;
      nib_q    <= nib_d;
      rdata_q  <= rdata_d;
      m_act_q  <= m_act_d;
      m_we_q   <= m_we_d;
      m_adr_q  <= m_adr_d;
      m_dat_q  <= m_dat_d;
      s0_ack_q <= s0_ack_d;
      s1_ack_q <= s1_ack_d;
      s0_dat_q <= s0_dat_d;
      s1_dat_q <= s1_dat_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    port_d    = port_q;
    nib_d     = nib_q;
    rdata_d   = rdata_q;
    m_act_d   = m_act_q;
    m_we_d    = m_we_q;
    m_adr_d   = m_adr_q;
    m_dat_d   = m_dat_q;
    s0_ack_d  = 1'b0;
    s1_ack_d  = 1'b0;
    s0_dat_d  = s0_dat_q;
    s1_dat_d  = s1_dat_q;
    arb_upd_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld_c) begin
          port_d  = gnt_idx_c;
          req_d   = in_req_c;
          nib_d   = '0;
          rdata_d = '0;
          state_d = in_ok_c ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        // Lanes with sel low are skipped without touching the backdoor.
        if (cur_en_c) begin
          m_act_d = 1'b1;
          m_we_d  = req_q.we;
          m_adr_d = nib_addr(req_q.word, nib_q, MEM_WORDS, STATUS_BASE);
          m_dat_d = req_q.wdata[{nib_q, 2'b00} +: 4];
          state_d = WAIT;
        end else if (nib_q == LAST_NIB) begin
          state_d = RESP;
        end else begin
          nib_d = nib_nxt_c;
        end
      end
      WAIT: begin
        if (m_ack_i) begin
          if (!req_q.we) rdata_d[{nib_q, 2'b00} +: 4] = m_dat_i[3:0];
          if (nib_q == LAST_NIB) begin
            m_act_d = 1'b0;
            m_we_d  = 1'b0;
            state_d = RESP;
          end else begin
            nib_d = nib_nxt_c;
            if (nxt_en_c) begin
              m_adr_d = nib_addr(req_q.word, nib_nxt_c, MEM_WORDS, STATUS_BASE);
              m_dat_d = req_q.wdata[{nib_nxt_c, 2'b00} +: 4];
            end else begin
              m_act_d = 1'b0;
              m_we_d  = 1'b0;
              state_d = ISSUE;
            end
          end
        end
      end
      RESP: begin
        arb_upd_c = 1'b1;
        state_d   = IDLE;
        if (!port_q) begin
          if (s0_cyc_i && s0_stb_i) begin
            s0_ack_d = 1'b1;
            s0_dat_d = rdata_q;
          end
        end else if (s1_cyc_i && s1_stb_i) begin
          s1_ack_d = 1'b1;
          s1_dat_d = rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign s0_ack_o = s0_ack_q;
  assign s1_ack_o = s1_ack_q;
  assign s0_dat_o = s0_dat_q;
  assign s1_dat_o = s1_dat_q;
  assign m_cyc_o  = m_act_q;
  assign m_stb_o  = m_act_q;
  assign m_we_o   = m_we_q;
  assign m_adr_o  = m_adr_q;
  assign m_dat_o  = {{(DATA_W-4){1'b0}}, m_dat_q};
  assign grant_o  = port_q;
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_ram_wb_word_arbiter.sv
// Scoreboard bench for ram_wb_word_arbiter: word-level reference memory, a
// nibble backdoor slave with random latency, directed cases and random traffic.
module tb_ram_wb_word_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        s0_cyc_i, s0_stb_i, s0_we_i, s1_cyc_i, s1_stb_i, s1_we_i;
  logic [31:0] s0_adr_i, s0_dat_i, s1_adr_i, s1_dat_i, s0_dat_o, s1_dat_o;
  logic        s0_ack_o, s1_ack_o;
  logic        m_cyc_o, m_stb_o, m_we_o, m_ack_i;
  logic [31:0] m_adr_o, m_dat_o, m_dat_i;
  logic        grant_o, busy_o;
`ifdef RAM_WB_SEL_EN
  logic [3:0]  s0_sel_i = 4'hF, s1_sel_i = 4'hF;
`endif

  always #5 clock = ~clock;

  ram_wb_word_arbiter dut (
    .clock(clock), .reset(reset),
`ifdef RAM_WB_SEL_EN
    .s0_sel_i(s0_sel_i), .s1_sel_i(s1_sel_i),
`endif
    .s0_cyc_i(s0_cyc_i), .s0_stb_i(s0_stb_i), .s0_we_i(s0_we_i), .s0_adr_i(s0_adr_i),
    .s0_dat_i(s0_dat_i), .s0_dat_o(s0_dat_o), .s0_ack_o(s0_ack_o),
    .s1_cyc_i(s1_cyc_i), .s1_stb_i(s1_stb_i), .s1_we_i(s1_we_i), .s1_adr_i(s1_adr_i),
    .s1_dat_i(s1_dat_i), .s1_dat_o(s1_dat_o), .s1_ack_o(s1_ack_o),
    .m_cyc_o(m_cyc_o), .m_stb_o(m_stb_o), .m_we_o(m_we_o), .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o), .m_dat_i(m_dat_i), .m_ack_i(m_ack_i),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  logic [31:0] ref_mem [10];
  logic [3:0]  bd_mem [128];
  logic [31:0] q0[$], q1[$], adr_log[$];
  int          gnt_log[$];
  int          checks = 0, errors = 0;
  int          bd_acks = 0, s0_acks = 0, s1_acks = 0, mcyc_cnt = 0;
  logic [31:0] exp_last1 = 32'h0;
  logic        busy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int nib_index(input int w, input int n);
    return (w < 8) ? w * 8 + n : 64 + (w - 8) * 8 + n;
  endfunction

  task automatic drive(input int p, input logic act, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (p == 0) begin
      s0_cyc_i = act; s0_stb_i = act; s0_we_i = we; s0_adr_i = adr; s0_dat_i = dat;
    end else begin
      s1_cyc_i = act; s1_stb_i = act; s1_we_i = we; s1_adr_i = adr; s1_dat_i = dat;
    end
  endtask

  // Full word transaction; expected response comes from the word-level model.
  task automatic wb_xfer(input int p, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, output int lat);
    int w;
    logic [31:0] exp;
    logic got;
    w = int'(adr[5:2]);
    exp = 32'h0;
    if (w < 10) begin
      if (we) ref_mem[w] = dat;
      else    exp = ref_mem[w];
    end
    if (p == 0) q0.push_back(exp); else q1.push_back(exp);
    @(negedge clock);
    drive(p, 1'b1, we, adr, dat);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 500) begin
      @(negedge clock);
      lat++;
      got = (p == 0) ? s0_ack_o : s1_ack_o;
    end
    check("ack_seen", 32'(got), 1);
    if (!got) begin
      if (p == 0) void'(q0.pop_back()); else void'(q1.pop_back());
    end
    drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic rand_port(input int p, input int n_tx);
    int lat, w;
    logic [31:0] adr;
    for (int i = 0; i < n_tx; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      if ($urandom_range(0, 5) == 0) w = int'($urandom_range(10, 15));
      else if (p == 0)               w = int'($urandom_range(0, 3));
      else                           w = int'($urandom_range(4, 9));
      adr = $urandom();
      adr[5:2] = 4'(w);
      wb_xfer(p, 1'($urandom_range(0, 1)), adr, $urandom(), lat);
    end
  endtask

  // Backdoor nibble RAM with random response latency.
  initial begin : bd_slave
    int dly;
    int a;
    dly = -1;
    m_ack_i = 1'b0;
    m_dat_i = 32'h0;
    forever begin
      @(negedge clock);
      if (m_ack_i) begin
        m_ack_i = 1'b0;
        dly = -1;
      end else if (!reset && m_cyc_o && m_stb_o) begin
        if (dly < 0) dly = int'($urandom_range(0, 5));
        if (dly == 0) begin
          check("bd_adr_range", (m_adr_o < 32'd80) ? 32'd1 : 32'd0, 1);
          a = int'(m_adr_o[6:0]);
          if (m_we_o) bd_mem[a] = m_dat_o[3:0];
          m_dat_i = {28'($urandom()), bd_mem[a]};
          adr_log.push_back(m_adr_o);
          bd_acks++;
          m_ack_i = 1'b1;
        end else begin
          dly--;
        end
      end else begin
        dly = -1;
      end
    end
  end

  // Response monitor: pops the scoreboard on every upstream ack.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clock);
      if (m_cyc_o) mcyc_cnt++;
      if (busy_o && !busy_prev) gnt_log.push_back(int'(grant_o));
      busy_prev = busy_o;
      if (s0_ack_o) begin
        s0_acks++;
        if (q0.size() == 0) check("s0_unexpected_ack", 1, 0);
        else begin e = q0.pop_front(); check("s0_rdata", s0_dat_o, e); end
      end
      if (s1_ack_o) begin
        s1_acks++;
        if (q1.size() == 0) check("s1_unexpected_ack", 1, 0);
        else begin e = q1.pop_front(); exp_last1 = e; check("s1_rdata", s1_dat_o, e); end
      end
    end
  end

  initial begin : stim
    int lat, n, a0, snap;
    logic [31:0] word;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 128; i++) bd_mem[i] = 4'h0;
    for (int w = 0; w < 10; w++) begin
      ref_mem[w] = $urandom();
      for (int k = 0; k < 8; k++) bd_mem[nib_index(w, k)] = ref_mem[w][4*k +: 4];
    end
    repeat (3) @(negedge clock);
    check("rst_m_ctrl", {29'h0, m_cyc_o, m_stb_o, m_we_o}, 0);
    check("rst_m_adr", m_adr_o, 0);
    check("rst_m_dat", m_dat_o, 0);
    check("rst_acks", {30'h0, s0_ack_o, s1_ack_o}, 0);
    check("rst_s0_dat", s0_dat_o, 0);
    check("rst_s1_dat", s1_dat_o, 0);
    check("rst_grant_busy", {30'h0, grant_o, busy_o}, 0);
    reset = 1'b0;

    // Tie from reset, then port 0 re-requests while port 1 is pending.
    gnt_log.delete();
    fork
      begin
        int l;
        wb_xfer(0, 1'b0, 32'h00, 32'h0, l);
        wb_xfer(0, 1'b1, 32'h04, $urandom(), l);
      end
      begin
        int l;
        wb_xfer(1, 1'b0, 32'h14, 32'h0, l);
      end
    join
    check("tie_grants", gnt_log.size(), 3);
    if (gnt_log.size() == 3) begin
      check("tie_grant0", gnt_log[0], 0);
      check("tie_grant1", gnt_log[1], 1);
      check("tie_grant2", gnt_log[2], 0);
    end

    // Port 0 word write to memory word 1.
    repeat (2) @(negedge clock);
    bd_acks = 0; adr_log.delete(); a0 = s0_acks;
    wb_xfer(0, 1'b1, 32'h04, 32'h87654321, lat);
    check("wr_bd_acks", bd_acks, 8);
    check("wr_s0_acks", s0_acks - a0, 1);
    for (int k = 0; k < 8; k++) check("wr_nibble", {28'h0, bd_mem[8 + k]}, k + 1);
    for (int k = 0; k < 8; k++)
      if (adr_log.size() > k) check("wr_adr_walk", adr_log[k], 8 + k);
    check("s1_dat_hold", s1_dat_o, exp_last1);

    // Status word read after backdoor pokes.
    for (int k = 0; k < 8; k++) bd_mem[64 + k] = 4'(10 - k);
    ref_mem[8] = 32'h3456789A;
    adr_log.delete();
    wb_xfer(1, 1'b0, 32'h20, 32'h0, lat);
    check("st_adr_count", adr_log.size(), 8);
    for (int k = 0; k < 8; k++)
      if (adr_log.size() > k) check("st_adr_walk", adr_log[k], 64 + k);

    // Invalid word index: fast zero response, backdoor untouched.
    snap = mcyc_cnt;
    wb_xfer(1, 1'b0, 32'h3C, 32'h0, lat);
    check("inv_latency_le2", (lat <= 2) ? 32'd1 : 32'd0, 1);
    check("inv_no_mcyc", mcyc_cnt, snap);

    // Port 0 abandons a write after three nibbles; all eight still land.
    bd_acks = 0; a0 = s0_acks;
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 32'h08, 32'hFFFFFFFF);
    n = 0;
    while (bd_acks < 3 && n < 500) begin @(negedge clock); n++; end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    ref_mem[2] = 32'hFFFFFFFF;
    n = 0;
    do begin @(negedge clock); n++; end while ((busy_o || m_cyc_o) && n < 500);
    check("drop_finished", (n < 500) ? 32'd1 : 32'd0, 1);
    repeat (3) @(negedge clock);
    check("drop_no_ack", s0_acks - a0, 0);
    check("drop_bd_acks", bd_acks, 8);
    for (int k = 0; k < 8; k++) word[4*k +: 4] = bd_mem[16 + k];
    check("drop_nibbles", word, 32'hFFFFFFFF);

    // Reset during the fifth nibble; rewrite the current value so contents are stable.
    bd_acks = 0;
    @(negedge clock);
    drive(0, 1'b1, 1'b1, 32'h0C, ref_mem[3]);
    n = 0;
    while (!(bd_acks >= 4 && m_cyc_o && !m_ack_i) && n < 500) begin @(negedge clock); n++; end
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clock);
    check("rst_mid_mcyc", {31'h0, m_cyc_o}, 0);
    check("rst_mid_busy", {31'h0, busy_o}, 0);
    check("rst_mid_adr", m_adr_o, 0);
    reset = 1'b0;
    wb_xfer(0, 1'b0, 32'h0C, 32'h0, lat);

    // Random concurrent traffic on disjoint words.
    fork
      rand_port(0, 20);
      rand_port(1, 20);
    join
    repeat (5) @(negedge clock);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
